// File: rtl/execute_stage_if.sv
// rtl/execute_stage_if.sv - issue/result/forwarding bundle between pipeline buffers and the execute stage
interface execute_stage_if #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 13
);
  logic              in_valid;
  logic              flush;
  logic [CTRL_W-1:0] ctrl_in;
  logic [3:0]        function_in;
  logic [DATA_W-1:0] readData1_in;
  logic [DATA_W-1:0] readData2_in;
  logic [2:0]        src1_addr;
  logic [2:0]        src2_addr;
  logic [2:0]        writeAdd_in1;
  logic [2:0]        writeAdd_in2;
  logic              em_regwr;
  logic              mw_regwr;
  logic [2:0]        em_wadd;
  logic [2:0]        mw_wadd;
  logic [DATA_W-1:0] em_data;
  logic [DATA_W-1:0] mw_data;
  logic              busy;
  logic              out_valid;
  logic [CTRL_W-1:0] ctrl_out;
  logic [DATA_W-1:0] result1_out;
  logic [DATA_W-1:0] result2_out;
  logic [2:0]        writeAdd_out1;
  logic [2:0]        writeAdd_out2;
  logic [2:0]        flags_out;

  modport master (
    output in_valid, flush, ctrl_in, function_in, readData1_in, readData2_in,
           src1_addr, src2_addr, writeAdd_in1, writeAdd_in2,
           em_regwr, mw_regwr, em_wadd, mw_wadd, em_data, mw_data,
    input  busy, out_valid, ctrl_out, result1_out, result2_out,
           writeAdd_out1, writeAdd_out2, flags_out
  );

  modport slave (
    input  in_valid, flush, ctrl_in, function_in, readData1_in, readData2_in,
           src1_addr, src2_addr, writeAdd_in1, writeAdd_in2,
           em_regwr, mw_regwr, em_wadd, mw_wadd, em_data, mw_data,
    output busy, out_valid, ctrl_out, result1_out, result2_out,
           writeAdd_out1, writeAdd_out2, flags_out
  );
endinterface

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - execute stage: operand forwarding, ALU, C/N/Z flags, shift-add multiplier
module execute_stage #(
  parameter int DATA_W     = 16,
  parameter int CTRL_W     = 13,
  parameter int MUL_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  execute_stage_if.slave  bus
);
  localparam int                CNT_W    = $clog2(MUL_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  localparam logic [3:0] OP_NOT  = 4'd1;
  localparam logic [3:0] OP_INC  = 4'd2;
  localparam logic [3:0] OP_DEC  = 4'd3;
  localparam logic [3:0] OP_MOV  = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_SHL  = 4'd9;
  localparam logic [3:0] OP_SHR  = 4'd10;
  localparam logic [3:0] OP_SETC = 4'd11;
  localparam logic [3:0] OP_CLRC = 4'd12;
  localparam logic [3:0] OP_MUL  = 4'd13;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_t;

  state_t              state;
  logic [DATA_W-1:0]   op_a, op_b;
  logic [2*DATA_W-1:0] mcand, acc, acc_next;
  logic [DATA_W-1:0]   mplier;
  logic [CNT_W-1:0]    cnt;
  logic [CTRL_W-1:0]   mul_ctrl;
  logic [2:0]          mul_wa1, mul_wa2;
  logic                flag_c, flag_n, flag_z;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c, c_upd, zn_upd;
  logic [DATA_W:0]     add_w, sub_w, inc_w, dec_w, shl_w, shr_w;
  logic                issue;

  assign issue         = bus.in_valid && !bus.flush;
  assign bus.flags_out = {flag_c, flag_n, flag_z};

  // EM is the younger producer, so it wins when both stages target the source
  always_comb begin
    op_a = bus.readData1_in;
    if (bus.em_regwr && bus.em_wadd == bus.src1_addr)      op_a = bus.em_data;
    else if (bus.mw_regwr && bus.mw_wadd == bus.src1_addr) op_a = bus.mw_data;
    op_b = bus.readData2_in;
    if (bus.em_regwr && bus.em_wadd == bus.src2_addr)      op_b = bus.em_data;
    else if (bus.mw_regwr && bus.mw_wadd == bus.src2_addr) op_b = bus.mw_data;
  end

  // One spare top bit holds carry/borrow; for shifts it catches the last bit shifted out
  assign add_w = {1'b0, op_a} + {1'b0, op_b};
  assign sub_w = {1'b0, op_a} - {1'b0, op_b};
  assign inc_w = {1'b0, op_a} + (DATA_W+1)'(1);
  assign dec_w = {1'b0, op_a} - (DATA_W+1)'(1);
  assign shl_w = {1'b0, op_a} << op_b[3:0];
  assign shr_w = {op_a, 1'b0} >> op_b[3:0];

  always_comb begin
    alu_res = op_a;
    alu_c   = flag_c;
    c_upd   = 1'b0;
    zn_upd  = 1'b1;
    case (bus.function_in)
      OP_NOT: alu_res = ~op_a;
      OP_INC: begin {alu_c, alu_res} = inc_w; c_upd = 1'b1; end
      OP_DEC: begin {alu_c, alu_res} = dec_w; c_upd = 1'b1; end
      OP_MOV: alu_res = op_b;
      OP_ADD: begin {alu_c, alu_res} = add_w; c_upd = 1'b1; end
      OP_SUB: begin {alu_c, alu_res} = sub_w; c_upd = 1'b1; end
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_SHL: begin {alu_c, alu_res} = shl_w; c_upd = |op_b[3:0]; end
      OP_SHR: begin
        alu_res = shr_w[DATA_W:1];
        alu_c   = shr_w[0];
        c_upd   = |op_b[3:0];
      end
      default: zn_upd = 1'b0;
    endcase
  end

  assign acc_next = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      bus.busy          <= 1'b0;
      bus.out_valid     <= 1'b0;
      bus.ctrl_out      <= '0;
      bus.result1_out   <= '0;
      bus.result2_out   <= '0;
      bus.writeAdd_out1 <= '0;
      bus.writeAdd_out2 <= '0;
      flag_c            <= 1'b0;
      flag_n            <= 1'b0;
      flag_z            <= 1'b0;
      mcand             <= '0;
      acc               <= '0;
      mplier            <= '0;
      cnt               <= '0;
      mul_ctrl          <= '0;
      mul_wa1           <= '0;
      mul_wa2           <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          bus.out_valid <= 1'b0;
          bus.ctrl_out  <= '0;
          state         <= ST_IDLE;
          if (issue && bus.function_in == OP_MUL) begin
            state    <= ST_MUL;
            bus.busy <= 1'b1;
            mcand    <= {{DATA_W{1'b0}}, op_a};
            mplier   <= op_b;
            acc      <= '0;
            cnt      <= '0;
            mul_ctrl <= bus.ctrl_in;
            mul_wa1  <= bus.writeAdd_in1;
            mul_wa2  <= bus.writeAdd_in2;
          end else if (issue) begin
            state             <= ST_DONE;
            bus.out_valid     <= 1'b1;
            bus.ctrl_out      <= bus.ctrl_in;
            bus.result1_out   <= alu_res;
            bus.result2_out   <= '0;
            bus.writeAdd_out1 <= bus.writeAdd_in1;
            bus.writeAdd_out2 <= bus.writeAdd_in2;
            if (bus.function_in == OP_SETC) begin
              flag_c <= 1'b1;
            end else if (bus.function_in == OP_CLRC) begin
              flag_c <= 1'b0;
            end else if (bus.ctrl_in[1] && zn_upd) begin
              flag_z <= (alu_res == '0);
              flag_n <= alu_res[DATA_W-1];
              if (c_upd) flag_c <= alu_c;
            end
          end
        end
        ST_MUL: begin
          bus.out_valid <= 1'b0;
          bus.ctrl_out  <= '0;
          if (bus.flush) begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
          end else begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST) begin
              state             <= ST_DONE;
              bus.busy          <= 1'b0;
              bus.out_valid     <= 1'b1;
              bus.ctrl_out      <= mul_ctrl;
              bus.result1_out   <= acc_next[DATA_W-1:0];
              bus.result2_out   <= acc_next[2*DATA_W-1:DATA_W];
              bus.writeAdd_out1 <= mul_wa1;
              bus.writeAdd_out2 <= mul_wa2;
              if (mul_ctrl[1]) begin
                flag_z <= (acc_next == '0);
                flag_n <= acc_next[2*DATA_W-1];
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - scoreboard bench for execute_stage against an arithmetic reference model
module tb_execute_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  execute_stage_if bus ();
  execute_stage dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b;
    logic [12:0] ctrl;
    logic [2:0]  src1, src2, wa1, wa2;
    logic        em_regwr, mw_regwr;
    logic [2:0]  em_wadd, mw_wadd;
    logic [15:0] em_data, mw_data;
    logic        v, fl;
  } stim_t;

  typedef struct {
    logic [15:0] r1, r2;
    logic [12:0] ctrl;
    logic [2:0]  wa1, wa2;
    logic [2:0]  flags;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic mc = 1'b0, mn = 1'b0, mz = 1'b0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] pick(input logic [2:0] src, input logic [15:0] bufv);
    if (bus.em_regwr && bus.em_wadd == src) return bus.em_data;
    if (bus.mw_regwr && bus.mw_wadd == src) return bus.mw_data;
    return bufv;
  endfunction

  function automatic stim_t base_stim();
    stim_t s;
    s = '{op: 4'd0, a: 16'h0, b: 16'h0, ctrl: 13'h0, src1: 3'd1, src2: 3'd2,
          wa1: 3'd4, wa2: 3'd5, em_regwr: 1'b0, mw_regwr: 1'b0, em_wadd: 3'd0,
          mw_wadd: 3'd0, em_data: 16'h0, mw_data: 16'h0, v: 1'b1, fl: 1'b0};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.op = 4'($urandom_range(0, 15));
    s.a  = 16'($urandom);
    s.b  = 16'($urandom);
    if ($urandom_range(0, 4) == 0) s.a = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'hFFFF;
    if ($urandom_range(0, 4) == 0) s.b = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'hFFFF;
    s.ctrl     = 13'($urandom);
    s.src1     = 3'($urandom);
    s.src2     = 3'($urandom);
    s.wa1      = 3'($urandom);
    s.wa2      = 3'($urandom);
    s.em_regwr = 1'($urandom);
    s.mw_regwr = 1'($urandom);
    s.em_wadd  = 3'($urandom);
    s.mw_wadd  = 3'($urandom);
    s.em_data  = 16'($urandom);
    s.mw_data  = 16'($urandom);
    s.v        = ($urandom_range(0, 5) != 0);
    s.fl       = ($urandom_range(0, 7) == 0);
    return s;
  endfunction

  task automatic drive(input stim_t s);
    bus.function_in  = s.op;
    bus.readData1_in = s.a;
    bus.readData2_in = s.b;
    bus.ctrl_in      = s.ctrl;
    bus.src1_addr    = s.src1;
    bus.src2_addr    = s.src2;
    bus.writeAdd_in1 = s.wa1;
    bus.writeAdd_in2 = s.wa2;
    bus.em_regwr     = s.em_regwr;
    bus.mw_regwr     = s.mw_regwr;
    bus.em_wadd      = s.em_wadd;
    bus.mw_wadd      = s.mw_wadd;
    bus.em_data      = s.em_data;
    bus.mw_data      = s.mw_data;
    bus.in_valid     = s.v;
    bus.flush        = s.fl;
  endtask

  // Reference: plain arithmetic on forwarded operands; updates the model flags
  task automatic model(input stim_t s, output exp_t e);
    logic [15:0] a, b, r;
    logic [31:0] p;
    logic c;
    bit cw, zn;
    int n, sum;
    a = pick(s.src1, s.a);
    b = pick(s.src2, s.b);
    p = 32'(a) * 32'(b);
    r = a; c = mc; cw = 0; zn = 1; n = int'(b[3:0]);
    case (s.op)
      4'd1:  r = ~a;
      4'd2:  begin r = a + 16'd1; c = (a == 16'hFFFF); cw = 1; end
      4'd3:  begin r = a - 16'd1; c = (a == 16'h0000); cw = 1; end
      4'd4:  r = b;
      4'd5:  begin sum = int'(a) + int'(b); r = sum[15:0]; c = (sum > 65535); cw = 1; end
      4'd6:  begin r = a - b; c = (a < b); cw = 1; end
      4'd7:  r = a & b;
      4'd8:  r = a | b;
      4'd9:  begin r = a << n; if (n != 0) begin c = a[16-n]; cw = 1; end end
      4'd10: begin r = a >> n; if (n != 0) begin c = a[n-1]; cw = 1; end end
      4'd13: ;
      default: zn = 0;
    endcase
    if (s.op == 4'd11) mc = 1'b1;
    else if (s.op == 4'd12) mc = 1'b0;
    else if (s.ctrl[1] && zn) begin
      if (s.op == 4'd13) begin mz = (p == 0); mn = p[31]; end
      else begin mz = (r == 0); mn = r[15]; end
      if (cw) mc = c;
    end
    e.r1    = (s.op == 4'd13) ? p[15:0] : r;
    e.r2    = (s.op == 4'd13) ? p[31:16] : 16'h0;
    e.ctrl  = s.ctrl;
    e.wa1   = s.wa1;
    e.wa2   = s.wa2;
    e.flags = {mc, mn, mz};
  endtask

  // mode 0: normal, 1: flush after k busy cycles, 2: reset after k busy cycles
  task automatic run_op(input stim_t s, input int mode, input int k);
    exp_t e;
    stim_t junk;
    int cnt;
    logic sc, sn, sz;
    bit starts_mul;
    @(negedge clk);
    drive(s);
    starts_mul = s.v && !s.fl && (s.op == 4'd13);
    if (s.v && !s.fl) begin
      sc = mc; sn = mn; sz = mz;
      model(s, e);
      if (starts_mul && mode != 0) begin mc = sc; mn = sn; mz = sz; end
      else sbq.push_back(e);
    end
    if (starts_mul) begin
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.busy !== 1'b1) break;
        cnt++;
        junk    = rand_stim();
        junk.v  = 1'b1;
        junk.fl = (mode == 1 && cnt == k);
        drive(junk);
        if (mode == 2 && cnt == k) begin
          rst = 1'b1;
          bus.in_valid = 1'b0;
        end
      end
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      chk("mul_busy_cycles", 32'(cnt), (mode == 0) ? 32'd16 : 32'(k));
      if (mode == 2) begin
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_flags", 32'(bus.flags_out), 32'd0);
        chk("rst_result1", 32'(bus.result1_out), 32'd0);
        chk("rst_result2", 32'(bus.result2_out), 32'd0);
        chk("rst_ctrl", 32'(bus.ctrl_out), 32'd0);
        rst = 1'b0;
        mc = 1'b0; mn = 1'b0; mz = 1'b0;
        sbq.delete();
      end
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.out_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual result1=%h required no output at %0t", bus.result1_out, $time);
        end else begin
          mon_e = sbq.pop_front();
          chk("result1", 32'(bus.result1_out), 32'(mon_e.r1));
          chk("result2", 32'(bus.result2_out), 32'(mon_e.r2));
          chk("ctrl_out", 32'(bus.ctrl_out), 32'(mon_e.ctrl));
          chk("wadd1", 32'(bus.writeAdd_out1), 32'(mon_e.wa1));
          chk("wadd2", 32'(bus.writeAdd_out2), 32'(mon_e.wa2));
          chk("flags", 32'(bus.flags_out), 32'(mon_e.flags));
        end
      end else begin
        chk("bubble_ctrl", 32'(bus.ctrl_out), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    int mode, k;
    drive(base_stim());
    bus.in_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_flags", 32'(bus.flags_out), 32'd0);
    chk("reset_result1", 32'(bus.result1_out), 32'd0);
    chk("reset_ctrl", 32'(bus.ctrl_out), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    s = base_stim(); s.op = 4'd5; s.a = 16'hFFFF; s.b = 16'h0001; s.ctrl = 13'h003;
    run_op(s, 0, 0); settle();
    chk("tp_add_valid", 32'(bus.out_valid), 32'd1);
    chk("tp_add_result", 32'(bus.result1_out), 32'h0000);
    chk("tp_add_flags", 32'(bus.flags_out), 32'b101);

    s = base_stim(); s.op = 4'd6; s.a = 16'h7777; s.b = 16'h0011; s.ctrl = 13'h003;
    s.src1 = 3'd3; s.src2 = 3'd5;
    s.em_regwr = 1'b1; s.em_wadd = 3'd3; s.em_data = 16'h0010;
    s.mw_regwr = 1'b1; s.mw_wadd = 3'd3; s.mw_data = 16'h0020;
    run_op(s, 0, 0); settle();
    chk("tp_fwd_result", 32'(bus.result1_out), 32'hFFFF);
    chk("tp_fwd_flags", 32'(bus.flags_out), 32'b110);

    s = base_stim(); s.op = 4'd13; s.a = 16'h1234; s.b = 16'h0100; s.ctrl = 13'h003;
    run_op(s, 0, 0);
    chk("tp_mul_valid", 32'(bus.out_valid), 32'd1);
    chk("tp_mul_lo", 32'(bus.result1_out), 32'h3400);
    chk("tp_mul_hi", 32'(bus.result2_out), 32'h0012);
    @(negedge clk);
    chk("tp_mul_one_cycle", 32'(bus.out_valid), 32'd0);

    s = base_stim(); s.op = 4'd13; s.a = 16'hFFFF; s.b = 16'hFFFF; s.ctrl = 13'h003;
    run_op(s, 1, 5);
    repeat (2) @(negedge clk);
    chk("tp_flush_flags", 32'(bus.flags_out), 32'({mc, mn, mz}));
    s = base_stim(); s.op = 4'd5; s.a = 16'h0002; s.b = 16'h0003; s.ctrl = 13'h003;
    run_op(s, 0, 0); settle();
    chk("tp_after_flush_add", 32'(bus.result1_out), 32'h0005);

    s = base_stim(); s.op = 4'd9; s.a = 16'h8001; s.b = 16'h0001; s.ctrl = 13'h003;
    run_op(s, 0, 0); settle();
    chk("tp_shl_result", 32'(bus.result1_out), 32'h0002);
    chk("tp_shl_c", 32'(bus.flags_out[2]), 32'd1);
    s = base_stim(); s.op = 4'd12; s.a = 16'h1234; s.ctrl = 13'h001;
    run_op(s, 0, 0); settle();
    chk("tp_clrc_result", 32'(bus.result1_out), 32'h1234);
    chk("tp_clrc_c", 32'(bus.flags_out[2]), 32'd0);

    s = base_stim(); s.op = 4'd13; s.a = 16'h4321; s.b = 16'h00FF; s.ctrl = 13'h003;
    run_op(s, 2, 7);

    for (int i = 0; i < 250; i++) begin
      s = rand_stim();
      mode = 0; k = 0;
      if (s.op == 4'd13 && $urandom_range(0, 3) == 0) begin
        mode = 1;
        k = $urandom_range(1, 16);
      end
      run_op(s, mode, k);
    end

    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage sitting directly downstream of the decode/execute pipeline buffer; consumes its control word, two operands, two write addresses and 4-bit function code.
- Performs forwarding-operand selection, ALU operations, the condition-flag register (Z/N/C) and a multi-cycle 16x16 multiply.
- Drives registered outputs to the execute/memory buffer and a busy stall request to the hazard logic.

Parameters:
- DATA_W, 16, operand/result width
- CTRL_W, 13, control word width (passed through untouched)
- MUL_CYCLES, 16, shift-add iterations for MUL

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operands/control valid this cycle
- flush  in  1  squash current issue (branch taken)
- ctrl_in  in  CTRL_W  control word; bit0 RegWrite, bit1 FlagWrite
- function_in  in  4  operation code
- readData1_in, readData2_in  in  DATA_W  operands A, B from buffer
- src1_addr, src2_addr  in  3  source register addresses of A, B
- writeAdd_in1, writeAdd_in2  in  3  destination addresses (low, high)
- em_regwr, mw_regwr  in  1  downstream stages will write a register
- em_wadd, mw_wadd  in  3  their destination addresses
- em_data, mw_data  in  DATA_W  their write data
- busy  out  1  stall request; upstream must hold inputs
- out_valid  out  1  outputs below hold a completed operation
- ctrl_out  out  CTRL_W  control word of completed operation
- result1_out, result2_out  out  DATA_W  low/primary result, high result (MUL only, else 0)
- writeAdd_out1, writeAdd_out2  out  3  destinations
- flags_out  out  3  {C,N,Z}

Behaviour:
- Reset: all outputs 0, flags 0, FSM IDLE, multiplier cleared. Reset aborts an in-flight MUL with no result.
- Forwarding, per operand: em_regwr and em_wadd==src addr -> em_data; else mw_regwr and match -> mw_data; else buffer operand. EM wins on a double match.
- Function codes:
  - 0 NOP: result = A; no flag change.
  - 1 NOT A; 2 INC A; 3 DEC A; 4 MOV: result = B.
  - 5 ADD; 6 SUB A-B; 7 AND; 8 OR.
  - 9 SHL A by B[3:0]; 10 SHR (logical) A by B[3:0].
  - 11 SETC; 12 CLRC.
  - 13 MUL.
  - 14-15 reserved: treated as NOP.
- Arithmetic and flags:
  - ADD/INC: C = carry out of bit 15.
  - SUB/DEC: C = borrow (1 when A<B unsigned, resp. A==0).
  - SHL: C = last bit shifted out. SHR: C = last bit shifted out. Shift by 0 leaves C unchanged.
  - Logic ops leave C unchanged.
  - Z = (result==0); N = result[15]. MUL: Z/N on the 32-bit product, N = product[31].
  - Flags update only when ctrl bit1=1 and the op completes un-flushed. SETC/CLRC always update C regardless of bit1.
- FSM IDLE/MUL/DONE:
  - IDLE: in_valid and not flush and not MUL -> register outputs next edge (latency 1), out_valid=1 for one cycle.
  - IDLE with MUL -> go to MUL, latch operands, busy=1 from the next cycle.
  - MUL: MUL_CYCLES shift-add iterations, then DONE.
  - DONE: outputs registered, result1 = product[15:0], result2 = product[31:16], out_valid=1, busy=0, return to IDLE. Total latency MUL_CYCLES+1 edges.
  - in_valid=0 or flush while in IDLE -> out_valid=0, ctrl_out=0 (bubble).
  - flush during MUL: abort, return to IDLE, no output, no flag write.
  - Inputs arriving while busy=1 are ignored.

Test Plan:
- ADD A=0xFFFF, B=0x0001, ctrl=0x003 -> next cycle result1=0x0000, flags C=1 Z=1 N=0, out_valid=1.
- Forward: src1=3, em_regwr=1, em_wadd=3, em_data=0x0010, mw also matching with 0x0020; SUB B=0x0011 -> result 0xFFFF, C=1 N=1.
- MUL 0x1234 x 0x0100 -> busy high 16 cycles, then result1=0x3400, result2=0x0012, out_valid one cycle.
- flush at cycle 5 of MUL -> no out_valid, flags unchanged; next ADD issues normally.
- SHL A=0x8001 by 1, FlagWrite=1 -> 0x0002, C=1; then CLRC -> C=0, result passes A.
- rst asserted mid-MUL -> next edge all outputs 0, busy=0, flags 0.
